// File: rtl/unloader_pkg.sv
// Shared types and helpers for the serial unloader block.
package unloader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The bit counter must be at least one bit wide, even for a single-bit word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_unloader_if.sv
// Parallel-load / serial-out handshake bundle between a producer and the unloader.
interface serial_unloader_if #(
  parameter int N = 8
);
  logic [N-1:0] valor_entrada;
  logic         load;
  logic         ready_in;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  logic         done;

  modport master (
    output valor_entrada, load, ready_in,
    input  bit_out, bit_valid, busy, done
  );

  modport slave (
    input  valor_entrada, load, ready_in,
    output bit_out, bit_valid, busy, done
  );
endinterface

// File: rtl/bit_counter.sv
// Down-counter with synchronous load and decrement enable; load wins over decrement.
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/serial_unloader.sv
// Captures an N-bit word on load and streams it out MSB first under a ready/valid handshake.
module serial_unloader
  import unloader_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_unloader_if.slave   bus
);

  localparam int CW = cnt_width(N);

  state_t         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt;
  logic           cnt_ld;
  logic           cnt_dec;

  bit_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .ld     (cnt_ld),
    .ld_val (CW'(N - 1)),
    .dec    (cnt_dec),
    .cnt    (cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    cnt_ld        = 1'b0;
    cnt_dec       = 1'b0;
    bus.bit_out   = 1'b0;
    bus.bit_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          sreg_d  = bus.valor_entrada;
          cnt_ld  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.bit_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.bit_out   = sreg_q[N-1];
        // The final transfer leaves the register alone; only DONE follows.
        if (bus.ready_in) begin
          if (cnt == '0) begin
            state_d = DONE;
          end else begin
            sreg_d  = sreg_q << 1;
            cnt_dec = 1'b1;
          end
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_unloader.sv
// Directed bench for serial_unloader (N=8 and N=1) with a bit-order scoreboard.
module tb_serial_unloader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_unloader_if #(.N(8)) i8 ();
  serial_unloader_if #(.N(1)) i1 ();

  serial_unloader #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(i8.slave));
  serial_unloader #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));

  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  int   done8 = 0;
  int   done1 = 0;
  logic q8[$];
  logic q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scores the state visible before the coming edge, then advances one cycle.
  task automatic cycle();
    if (i8.bit_valid === 1'b1) begin
      if (i8.ready_in) begin
        if (q8.size() == 0) chk("bit8_extra", 32'(i8.bit_out), 32'hEE);
        else chk("bit8", 32'(i8.bit_out), 32'(q8.pop_front()));
      end else if (q8.size() != 0) begin
        chk("hold8", 32'(i8.bit_out), 32'(q8[0]));
      end
    end
    if (i1.bit_valid === 1'b1 && i1.ready_in) begin
      if (q1.size() == 0) chk("bit1_extra", 32'(i1.bit_out), 32'hEE);
      else chk("bit1", 32'(i1.bit_out), 32'(q1.pop_front()));
    end
    if (i8.done === 1'b1) done8++;
    if (i1.done === 1'b1) done1++;
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] val);
    i8.valor_entrada = val;
    i8.load = 1'b1;
    for (int b = 7; b >= 0; b--) q8.push_back(val[b]);
    cycle();
    i8.load = 1'b0;
  endtask

  // Entered in the first SHIFT cycle (k+1); returns in the done cycle.
  task automatic run_to_done(input string tag, input int exp_lat, input bit toggle, input int pulse_at);
    int cyc = 1;
    i8.ready_in = 1'b1;
    while (i8.done !== 1'b1 && cyc < 60) begin
      if (pulse_at != 0 && cyc == pulse_at) begin
        i8.load = 1'b1;
        i8.valor_entrada = 8'h00;
      end else begin
        i8.load = 1'b0;
      end
      cycle();
      cyc++;
      if (toggle) i8.ready_in = cyc[0];
    end
    i8.load = 1'b0;
    i8.ready_in = 1'b1;
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_qempty"}, 32'(q8.size()), 0);
  endtask

  initial begin
    int d0;
    reset = 1'b0;
    i8.valor_entrada = '0; i8.load = 1'b0; i8.ready_in = 1'b1;
    i1.valor_entrada = '0; i1.load = 1'b0; i1.ready_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_outs8", {28'd0, i8.bit_out, i8.bit_valid, i8.busy, i8.done}, 0);
    chk("rst_outs1", {28'd0, i1.bit_out, i1.bit_valid, i1.busy, i1.done}, 0);
    reset = 1'b1;
    cycle();

    // A5 with ready held high
    load8(8'hA5);
    chk("a5_valid", {30'd0, i8.bit_valid, i8.busy}, 32'h3);
    chk("a5_first", 32'(i8.bit_out), 1);
    d0 = done8;
    run_to_done("a5", 9, 1'b0, 0);
    chk("a5_done_busy", {30'd0, i8.done, i8.busy}, 32'h2);
    cycle();
    chk("a5_done_pulse", {30'd0, i8.done, i8.bit_valid}, 0);
    chk("a5_done_cnt", 32'(done8 - d0), 1);

    // F0 with ready toggling; bits must hold across stalls
    load8(8'hF0);
    run_to_done("f0", 16, 1'b1, 0);
    cycle();

    // FF with a stray load of 00 mid-shift
    load8(8'hFF);
    d0 = done8;
    run_to_done("ff", 9, 1'b0, 3);
    cycle();
    chk("ff_done_once", 32'(done8 - d0), 1);
    chk("ff_idle", {30'd0, i8.bit_valid, i8.busy}, 0);

    // Reset after three bits of C3, with load asserted in the reset cycle
    load8(8'hC3);
    repeat (3) cycle();
    d0 = done8;
    reset = 1'b0;
    i8.load = 1'b1;
    i8.valor_entrada = 8'hFF;
    cycle();
    q8.delete();
    chk("rst_mid_outs", {28'd0, i8.bit_out, i8.bit_valid, i8.busy, i8.done}, 0);
    reset = 1'b1;
    i8.load = 1'b0;
    cycle();
    chk("rst_mid_idle", {28'd0, i8.bit_out, i8.bit_valid, i8.busy, i8.done}, 0);
    chk("rst_mid_nodone", 32'(done8 - d0), 0);
    load8(8'h81);
    run_to_done("x81", 9, 1'b0, 0);

    // Load during DONE is ignored; load in the following IDLE cycle is taken
    i8.load = 1'b1;
    i8.valor_entrada = 8'hFF;
    cycle();
    chk("after_done_idle", {30'd0, i8.bit_valid, i8.busy}, 0);
    load8(8'h96);
    chk("b2b_valid", 32'(i8.bit_valid), 1);
    run_to_done("x96", 9, 1'b0, 0);
    cycle();

    // N=1 single bit
    i1.valor_entrada = 1'b1;
    i1.load = 1'b1;
    q1.push_back(1'b1);
    cycle();
    i1.load = 1'b0;
    chk("n1_valid", {30'd0, i1.bit_valid, i1.bit_out}, 32'h3);
    d0 = done1;
    cycle();
    chk("n1_done", {30'd0, i1.done, i1.bit_valid}, 32'h2);
    cycle();
    chk("n1_pulse", 32'(i1.done), 0);
    chk("n1_done_cnt", 32'(done1 - d0), 1);
    chk("n1_qempty", 32'(q1.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
